// File: rtl/memmux_pkg.sv
// Shared constants and helpers for the memmux_hs 1-to-N memory interconnect.
package memmux_pkg;

    // Fill bit for read data returned with decode-error and timeout responses.
    localparam logic ERR_FILL = 1'b0;

    // Width of a target id: slaves 0..SLAVES-1 plus the internal error target.
    function automatic int unsigned id_width(input int unsigned slaves);
        return $clog2(slaves + 1);
    endfunction

    // Id of the internal error target for unmapped addresses.
    function automatic int unsigned err_id(input int unsigned slaves);
        return slaves;
    endfunction

endpackage

// File: rtl/memmux_idfifo.sv
// Synchronous FIFO with async reset and head/tail/occupancy visibility.
// It holds the in-order list of outstanding transaction ids.
module memmux_idfifo
    import memmux_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAIL_W = WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [TAIL_W-1:0]        tail,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned IW = (PW == 0) ? 1 : PW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] last_entry;

    // Pointers carry one wrap bit; the storage index drops it.
    function automatic logic [IW-1:0] slot(input logic [PW:0] ptr);
        if (PW == 0) begin
            return '0;
        end
        return IW'(ptr);
    endfunction

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == (PW + 1)'(DEPTH));
    assign empty      = (count == '0);
    assign head       = mem[slot(rd_ptr)];
    assign last_entry = mem[slot(wr_ptr - 1'b1)];
    assign tail       = last_entry[TAIL_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[slot(wr_ptr)] <= wdata;
        end
    end

endmodule

// File: rtl/memmux_hs.sv
// 1-master to N-slave req/gnt + rvalid interconnect with in-order outstanding
// tracking, decode-error target and per-transaction response watchdog.
module memmux_hs
    import memmux_pkg::*;
#(
    parameter int unsigned             SLAVES     = 4,
    parameter int unsigned             AW         = 32,
    parameter int unsigned             DW         = 32,
    parameter logic [SLAVES*AW-1:0]    MATCH_ADDR = '0,
    parameter logic [SLAVES*AW-1:0]    MATCH_MASK = '0,
    parameter int unsigned             MAX_OUTST  = 2,
    parameter int unsigned             TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mReq,
    output logic                       mGnt,
    input  logic [DW/8-1:0]            mWrite,
    input  logic [AW-1:0]              mAddr,
    input  logic [DW-1:0]              mWData,
    output logic                       mRValid,
    output logic [DW-1:0]              mRData,
    output logic                       mErr,
    output logic [SLAVES-1:0]          sReq,
    input  logic [SLAVES-1:0]          sGnt,
    output logic [SLAVES*DW/8-1:0]     sWrite,
    output logic [SLAVES*AW-1:0]       sAddr,
    output logic [SLAVES*DW-1:0]       sWData,
    input  logic [SLAVES-1:0]          sRValid,
    input  logic [SLAVES*DW-1:0]       sRData
);

    localparam int unsigned    BW      = DW / 8;
    localparam int unsigned    IDW     = id_width(SLAVES);
    localparam int unsigned    ERR_ID  = err_id(SLAVES);
    localparam logic [IDW-1:0] ERR_SEL = IDW'(ERR_ID);
    localparam int unsigned    WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned    CW      = $clog2(MAX_OUTST) + 1;

    logic [IDW-1:0] sel;
    logic           hit;
    logic           sel_err;
    logic           sel_gnt;
    logic           can_issue;
    logic           accept;

    logic [IDW:0]   push_entry;
    logic [IDW:0]   head_entry;
    logic [IDW-1:0] head_id;
    logic           head_wr;
    logic           head_err;
    logic [IDW-1:0] tail_id;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;

    logic           rsp_valid;
    logic [DW-1:0]  rsp_data;
    logic           timeout;
    logic           pop;
    logic [WDW-1:0] wd;

    // Address decode: lowest matching slave wins, otherwise the error target.
    always_comb begin
        sel = ERR_SEL;
        hit = 1'b0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            if (!hit && ((mAddr & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW])) begin
                sel = IDW'(i);
                hit = 1'b1;
            end
        end
    end

    assign sel_err = (sel == ERR_SEL);

    // Issue only to the slave already owning the outstanding list; a switch
    // is also allowed when the sole outstanding entry retires this cycle.
    // Held low during reset so nothing is accepted while rst is asserted.
    assign can_issue = !rst && !full &&
                       (empty || (tail_id == sel) || ((count == CW'(1)) && pop));

    assign accept = mReq && can_issue && sel_gnt;
    assign mGnt   = accept;

    assign sAddr  = {SLAVES{mAddr}};
    assign sWData = {SLAVES{mWData}};

    // Per-slave request steering and head-slave response selection.
    always_comb begin
        sel_gnt   = sel_err;
        sReq      = '0;
        sWrite    = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            if (sel == IDW'(i)) begin
                sel_gnt             = sGnt[i];
                sReq[i]             = mReq && can_issue;
                sWrite[i*BW +: BW]  = mWrite;
            end
            if (head_id == IDW'(i)) begin
                rsp_valid = sRValid[i];
                rsp_data  = sRData[i*DW +: DW];
            end
        end
    end

    assign push_entry = {(mWrite != '0), sel};
    assign head_id    = head_entry[IDW-1:0];
    assign head_wr    = head_entry[IDW];
    assign head_err   = (head_id == ERR_SEL);

    memmux_idfifo #(
        .WIDTH  (IDW + 1),
        .DEPTH  (MAX_OUTST),
        .TAIL_W (IDW)
    ) u_idfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (push_entry),
        .head  (head_entry),
        .tail  (tail_id),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign timeout = (TIMEOUT != 0) && (wd == WDW'(TIMEOUT));
    assign pop     = !empty && (head_err || rsp_valid || timeout);

    assign mRValid = pop;
    assign mErr    = pop && (head_err || !rsp_valid);
    assign mRData  = (pop && rsp_valid && !head_wr && !head_err) ? rsp_data : {DW{ERR_FILL}};

    // Watchdog restarts whenever a new entry reaches head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else if (empty || pop) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

endmodule

// File: tb/tb_memmux_hs.sv
// Scoreboard bench for memmux_hs: behavioural slaves, address-map reference
// model, directed handshake scenarios followed by randomized traffic.
module tb_memmux_hs;

    localparam int unsigned SLAVES    = 4;
    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned BW        = DW / 8;
    localparam int unsigned MAX_OUTST = 2;
    localparam int unsigned TIMEOUT   = 8;

    // slave0: 0x0xxx_xxxx, slave1: 0x0/0x1 (loses 0x0 to slave0),
    // slave2: 0x2xxx_xxxx, slave3: 0x3xxx_xxxx (never responds), rest unmapped.
    localparam logic [SLAVES*AW-1:0] MAP_ADDR =
        {32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [SLAVES*AW-1:0] MAP_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hE000_0000, 32'hF000_0000};

    logic                   clk;
    logic                   rst;
    logic                   mReq;
    logic                   mGnt;
    logic [BW-1:0]          mWrite;
    logic [AW-1:0]          mAddr;
    logic [DW-1:0]          mWData;
    logic                   mRValid;
    logic [DW-1:0]          mRData;
    logic                   mErr;
    logic [SLAVES-1:0]      sReq;
    logic [SLAVES-1:0]      sGnt;
    logic [SLAVES*BW-1:0]   sWrite;
    logic [SLAVES*AW-1:0]   sAddr;
    logic [SLAVES*DW-1:0]   sWData;
    logic [SLAVES-1:0]      sRValid;
    logic [SLAVES*DW-1:0]   sRData;

    memmux_hs #(
        .SLAVES     (SLAVES),
        .AW         (AW),
        .DW         (DW),
        .MATCH_ADDR (MAP_ADDR),
        .MATCH_MASK (MAP_MASK),
        .MAX_OUTST  (MAX_OUTST),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mReq    (mReq),
        .mGnt    (mGnt),
        .mWrite  (mWrite),
        .mAddr   (mAddr),
        .mWData  (mWData),
        .mRValid (mRValid),
        .mRData  (mRData),
        .mErr    (mErr),
        .sReq    (sReq),
        .sGnt    (sGnt),
        .sWrite  (sWrite),
        .sAddr   (sAddr),
        .sWData  (sWData),
        .sRValid (sRValid),
        .sRData  (sRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference address map written from the table above.
    function automatic int exp_target(input logic [31:0] a);
        logic [3:0] nib;
        nib = a[31:28];
        if (nib <= 4'd3) return int'(nib);
        return 4;
    endfunction

    function automatic logic [31:0] slave_data(input int i, input logic [31:0] a);
        return (a * 32'd3) ^ (32'h5A00_0000 + 32'(i));
    endfunction

    // ---------------- behavioural slaves ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t sq [SLAVES][$];
    int   lat_fix [SLAVES];
    bit   gnt_always;
    bit   hang3;
    bit   inject0;

    initial begin
        int   lat;
        rsp_t r;
        sGnt    = '0;
        sRValid = '0;
        sRData  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < int'(SLAVES); i++) begin
                if (rst) begin
                    sq[i].delete();
                end else begin
                    if (sRValid[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                    if (sReq[i] && sGnt[i] && !(i == 3 && hang3)) begin
                        lat    = (lat_fix[i] != 0) ? lat_fix[i] : int'($urandom_range(1, 5));
                        r.due  = cyc + lat;
                        r.data = slave_data(i, sAddr[i*AW +: AW]);
                        sq[i].push_back(r);
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(SLAVES); i++) begin
                if (rst) sq[i].delete();
                sGnt[i] = gnt_always || ($urandom_range(0, 3) != 0);
                if (sq[i].size() > 0 && sq[i][0].due <= cyc) begin
                    sRValid[i]         = 1'b1;
                    sRData[i*DW +: DW] = sq[i][0].data;
                end else begin
                    sRValid[i]         = 1'b0;
                    sRData[i*DW +: DW] = $urandom;
                end
            end
            if (inject0) begin
                sRValid[0]    = 1'b1;
                sRData[31:0]  = 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb [$];
    int   rsp_log [$];
    int   last_tgt = -1;

    initial begin
        int                   n;
        int                   tgt;
        logic                 exp_gnt;
        logic [SLAVES-1:0]    allowed;
        logic [SLAVES*BW-1:0] exp_sw;
        exp_t                 e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                n   = sb.size();
                tgt = exp_target(mAddr);

                exp_gnt = mReq && (n < int'(MAX_OUTST)) &&
                          (n == 0 || last_tgt == tgt || (n == 1 && mRValid)) &&
                          (tgt == 4 || sGnt[tgt]);
                check(mGnt == exp_gnt, "grant_rule", 64'(mGnt), 64'(exp_gnt));

                allowed = '0;
                if (mReq && tgt < 4) allowed[tgt] = 1'b1;
                check((sReq & ~allowed) == '0, "sreq_decode", 64'(sReq), 64'(allowed));
                if (mGnt && tgt < 4) check(sReq[tgt] == 1'b1, "sreq_on_grant", 64'(sReq), 64'(allowed));

                exp_sw = '0;
                if (tgt < 4) exp_sw[tgt*BW +: BW] = mWrite;
                check(sWrite == exp_sw, "swrite_gate", 64'(sWrite), 64'(exp_sw));
                if (mReq) check(sAddr == {SLAVES{mAddr}}, "saddr_bcast", 64'(sAddr[63:0]), 64'({2{mAddr}}));

                if (mRValid) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_rsp", 64'(mRData), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check(mErr == e.err, "rsp_err", 64'(mErr), 64'(e.err));
                        check(mRData == e.data, "rsp_data", 64'(mRData), 64'(e.data));
                        rsp_log.push_back(cyc);
                    end
                end

                if (mGnt) begin
                    if (tgt >= 3) begin
                        e.err = 1'b1; e.data = '0;
                    end else if (mWrite != '0) begin
                        e.err = 1'b0; e.data = '0;
                    end else begin
                        e.err = 1'b0; e.data = slave_data(tgt, mAddr);
                    end
                    sb.push_back(e);
                    last_tgt = tgt;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [31:0] a, input logic [BW-1:0] be, output int gcyc);
        int w;
        w      = 0;
        mReq   = 1'b1;
        mAddr  = a;
        mWrite = be;
        mWData = $urandom;
        gcyc   = -1;
        while (gcyc < 0) begin
            @(negedge clk);
            if (mGnt) begin
                gcyc = cyc;
            end else begin
                w++;
                if (w > 200) begin
                    check(1'b0, "grant_timeout", 64'(0), 64'(1));
                    gcyc = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mReq   = 1'b0;
        mWrite = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        check(sb.size() == 0, "drain", 64'(sb.size()), 64'(0));
    endtask

    function automatic int first_rsp();
        if (rsp_log.size() == 0) return -1000;
        return rsp_log[0];
    endfunction

    initial begin
        int g, g1, g2, g3, s;
        logic [31:0] addr;
        int r;

        rst        = 1'b1;
        mReq       = 1'b1;
        mAddr      = 32'h1000_0000;
        mWrite     = '0;
        mWData     = '0;
        gnt_always = 1'b1;
        hang3      = 1'b1;
        inject0    = 1'b0;
        for (int i = 0; i < int'(SLAVES); i++) lat_fix[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check(mGnt == 1'b0, "rst_mgnt", 64'(mGnt), 64'(0));
        check(sReq == '0, "rst_sreq", 64'(sReq), 64'(0));
        check(mRValid == 1'b0, "rst_rvalid", 64'(mRValid), 64'(0));
        check(mErr == 1'b0, "rst_err", 64'(mErr), 64'(0));
        check(mRData == '0, "rst_rdata", 64'(mRData), 64'(0));
        mReq = 1'b0;
        rst  = 1'b0;
        idle(2);

        // 1: slave 1 read, fixed latency 3
        lat_fix[1] = 3;
        rsp_log.delete();
        s = cyc;
        issue(32'h1000_0004, '0, g);
        idle(1);
        drain();
        check(g == s, "t1_gnt_same_cycle", 64'(g - s), 64'(0));
        check(first_rsp() - g == 3, "t1_latency", 64'(first_rsp() - g), 64'(3));

        // 2: unmapped -> error response next cycle
        rsp_log.delete();
        s = cyc;
        issue(32'hF000_0000, '0, g);
        idle(1);
        drain();
        check(g == s, "t2_gnt_same_cycle", 64'(g - s), 64'(0));
        check(first_rsp() - g == 1, "t2_latency", 64'(first_rsp() - g), 64'(1));

        // 3: three reads to slave 0, depth 2
        lat_fix[0] = 4;
        rsp_log.delete();
        issue(32'h0000_0010, '0, g1);
        issue(32'h0000_0014, '0, g2);
        issue(32'h0000_0018, '0, g3);
        idle(1);
        drain();
        check(g2 == g1 + 1, "t3_second_gnt", 64'(g2 - g1), 64'(1));
        check(g3 == first_rsp() + 1, "t3_third_held", 64'(g3), 64'(first_rsp() + 1));
        check(rsp_log.size() == 3, "t3_rsp_count", 64'(rsp_log.size()), 64'(3));

        // 4: slave-switch hazard, accept on the retiring cycle
        rsp_log.delete();
        issue(32'h0000_0020, '0, g1);
        issue(32'h2000_0040, '0, g2);
        idle(1);
        drain();
        check(g2 == first_rsp(), "t4_switch_gnt", 64'(g2), 64'(first_rsp()));

        // 5: hung slave -> watchdog error, then a normal read
        rsp_log.delete();
        issue(32'h3000_0000, '0, g);
        idle(1);
        drain();
        check(first_rsp() == g + 1 + int'(TIMEOUT), "t5_timeout_cycle",
              64'(first_rsp() - g), 64'(1 + TIMEOUT));
        rsp_log.delete();
        issue(32'h1000_0100, '0, g);
        idle(1);
        drain();
        check(rsp_log.size() == 1, "t5_followup", 64'(rsp_log.size()), 64'(1));

        // 6: async reset with two outstanding, then a stale slave response
        lat_fix[0] = 6;
        issue(32'h0000_0030, '0, g1);
        issue(32'h0000_0034, '0, g2);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check(mGnt == 1'b0, "t6_rst_mgnt", 64'(mGnt), 64'(0));
        check(sReq == '0, "t6_rst_sreq", 64'(sReq), 64'(0));
        check(mRValid == 1'b0, "t6_rst_rvalid", 64'(mRValid), 64'(0));
        mReq = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst     = 1'b0;
        inject0 = 1'b1;
        @(posedge clk);
        #2;
        check(mRValid == 1'b0, "t6_stale_ignored", 64'(mRValid), 64'(0));
        inject0 = 1'b0;
        idle(3);
        drain();
        lat_fix[0] = 0;
        lat_fix[1] = 0;

        // randomized traffic
        gnt_always = 1'b0;
        for (int t = 0; t < 400; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 28)      addr = {4'h0, 28'($urandom)};
            else if (r < 56) addr = {4'h1, 28'($urandom)};
            else if (r < 84) addr = {4'h2, 28'($urandom)};
            else if (r < 88) addr = {4'h3, 28'($urandom)};
            else             addr = {4'($urandom_range(4, 15)), 28'($urandom)};
            addr[1:0] = 2'b00;
            issue(addr, ($urandom_range(0, 1) != 0) ? BW'($urandom) : '0, g);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d required=<50000 cycles", cyc);
        $fatal(1);
    end

endmodule
